regfile_mp: RTL and testbench

//  Multi-read-port, byte-writable register file; next generation of the single-port memory block.
//  One write port with byte enables, NUM_RD independent registered read ports with per-port valid.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_rd_port.sv | 87 ++++++++
 rtl/regfile_mp.sv | 142 ++++++++++++++
 tb/tb_regfile_mp.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and byte helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {IDLE, CLEAR} clr_state_e;

    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       be
    );
        return be ? new_b : old_b;
    endfunction

    // Parity bit that makes the byte plus its parity bit hold an even number of ones
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port with write bypass and range check.
// Optional rd_perr output when REGFILE_PARITY_EN is defined.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              busy_i,
    input  logic [WIDTH-1:0]  mem_word_i,
    input  logic              wr_ok_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_word_i,
`ifdef REGFILE_PARITY_EN
    input  logic [WIDTH/8-1:0] mem_par_i,
    input  logic [WIDTH/8-1:0] wr_par_i,
    output logic               rd_perr_o,
`endif
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_valid_o,
    output logic              rd_err_o
);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic             in_rng;
    logic             hit;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    assign in_rng   = {1'b0, rd_addr_i} < DEPTH_L;
    assign hit      = wr_ok_i && (wr_addr_i == rd_addr_i);
    assign word     = hit ? wr_word_i : mem_word_i;
    assign rd_err_o = rd_en_i && !in_rng;

    always_comb begin
        data_d = '0;
        if (in_rng && !busy_i)
            data_d = word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_en_i;
            if (rd_en_i)
                data_q <= data_d;
        end
    end

    assign rd_data_o  = data_q;
    assign rd_valid_o = valid_q;

`ifdef REGFILE_PARITY_EN
    logic [WIDTH/8-1:0] par;
    logic               perr_d;
    logic               perr_q;

    assign par = hit ? wr_par_i : mem_par_i;

    always_comb begin
        perr_d = 1'b0;
        for (int i = 0; i < WIDTH / 8; i++)
            perr_d = perr_d | (even_parity(word[8*i +: 8]) != par[i]);
        if (!in_rng || busy_i)
            perr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            perr_q <= 1'b0;
        else if (rd_en_i)
            perr_q <= perr_d;
    end

    assign rd_perr_o = perr_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: byte-writable register file, NUM_RD registered read ports, bulk clear FSM.
// Per-byte even parity storage is added when REGFILE_PARITY_EN is defined.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NUM_RD = 2,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB     = WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NB-1:0]            wr_be,
    input  logic [WIDTH-1:0]         wr_data,
`ifdef REGFILE_PARITY_EN
    input  logic                     wr_perr_inj,
    output logic [NUM_RD-1:0]        rd_perr,
`endif
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     addr_err
);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              err_q;
    logic              err_d;
    logic              wr_rng;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_idx;
    logic [WIDTH-1:0]  wr_word;
    logic [NUM_RD-1:0] rd_err;

    assign clr_busy = (state_q == CLEAR);
    assign addr_err = err_q;
    assign wr_rng   = {1'b0, wr_addr} < DEPTH_L;
    assign wr_idx   = wr_rng ? wr_addr : '0;
    assign wr_ok    = wr_en && !clr_busy && wr_rng;
    assign err_d    = (wr_en && !clr_busy && !wr_rng) || (|rd_err);

    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NB; i++)
            wr_word[8*i +: 8] = byte_merge(mem_q[wr_idx][8*i +: 8],
                                           wr_data[8*i +: 8], wr_be[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            state_q <= IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                IDLE: begin
                    if (wr_ok)
                        mem_q[wr_idx] <= wr_word;
                    if (clr_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                    end
                end
                CLEAR: begin
                    mem_q[ptr_q] <= '0;
                    ptr_q        <= ptr_q + 1'b1;
                    if (ptr_q == LAST)
                        state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef REGFILE_PARITY_EN
    logic [NB-1:0] par_q [DEPTH];
    logic [NB-1:0] wr_par;

    // Injection only flips byte 0, and only when that byte is actually written
    always_comb begin
        wr_par = par_q[wr_idx];
        for (int i = 0; i < NB; i++)
            if (wr_be[i])
                wr_par[i] = even_parity(wr_data[8*i +: 8])
                          ^ ((i == 0) && wr_perr_inj);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                par_q[i] <= '0;
        end else if (clr_busy) begin
            par_q[ptr_q] <= '0;
        end else if (wr_ok) begin
            par_q[wr_idx] <= wr_par;
        end
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] ri;

        assign ra = rd_addr[p*ADDR_W +: ADDR_W];
        assign ri = ({1'b0, ra} < DEPTH_L) ? ra : '0;

        regfile_rd_port #(
            .WIDTH(WIDTH),
            .DEPTH(DEPTH)
        ) u_rd (
            .clk       (clk),
            .rst       (rst),
            .rd_en_i   (rd_en[p]),
            .rd_addr_i (ra),
            .busy_i    (clr_busy),
            .mem_word_i(mem_q[ri]),
            .wr_ok_i   (wr_ok),
            .wr_addr_i (wr_idx),
            .wr_word_i (wr_word),
`ifdef REGFILE_PARITY_EN
            .mem_par_i (par_q[ri]),
            .wr_par_i  (wr_par),
            .rd_perr_o (rd_perr[p]),
`endif
            .rd_data_o (rd_data[p*WIDTH +: WIDTH]),
            .rd_valid_o(rd_valid[p]),
            .rd_err_o  (rd_err[p])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random stimulus against a word-array reference model.
// DEPTH=12 so that addresses 12..15 exercise the out-of-range path.
module tb_regfile_mp;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 12;
    localparam int NUM_RD = 2;
    localparam int AW     = 4;
    localparam int NB     = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_en = 1'b0;
    logic [AW-1:0]         wr_addr = '0;
    logic [NB-1:0]         wr_be = '0;
    logic [WIDTH-1:0]      wr_data = '0;
    logic [NUM_RD-1:0]     rd_en = '0;
    logic [NUM_RD*AW-1:0]  rd_addr = '0;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]     rd_valid;
    logic                  clr_req = 1'b0;
    logic                  clr_busy;
    logic                  addr_err;
`ifdef REGFILE_PARITY_EN
    logic                  wr_perr_inj = 1'b0;
    logic [NUM_RD-1:0]     rd_perr;
`endif

    always #5 clk = ~clk;

    regfile_mp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NUM_RD(NUM_RD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_be   (wr_be),
        .wr_data (wr_data),
`ifdef REGFILE_PARITY_EN
        .wr_perr_inj(wr_perr_inj),
        .rd_perr (rd_perr),
`endif
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .addr_err(addr_err)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [DEPTH];
    bit          ref_bad [DEPTH];
    int          clr_left = 0;
    logic [31:0] exp_data [NUM_RD];
    bit          exp_perr [NUM_RD];
    bit          inj = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit [NUM_RD-1:0] ev, input bit eerr);
        for (int p = 0; p < NUM_RD; p++) begin
            chk($sformatf("valid%0d", p), rd_valid[p], ev[p]);
            chk($sformatf("data%0d", p), rd_data[p*WIDTH +: WIDTH], exp_data[p]);
`ifdef REGFILE_PARITY_EN
            chk($sformatf("perr%0d", p), rd_perr[p], exp_perr[p]);
`endif
        end
        chk("addr_err", addr_err, eerr);
        chk("clr_busy", clr_busy, clr_left > 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = '0;
        clr_req = 1'b0;
        @(posedge clk);
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = '0;
            ref_bad[a] = 1'b0;
        end
        clr_left = 0;
        for (int p = 0; p < NUM_RD; p++) begin
            exp_data[p] = '0;
            exp_perr[p] = 1'b0;
        end
        check_outputs('0, 1'b0);
        rst = 1'b0;
    endtask

    // One clock: drive inputs, predict from the model, then compare after the edge
    task automatic step(input bit we, input int wa, input logic [3:0] be,
                        input logic [31:0] wd, input bit [1:0] re,
                        input int ra0, input int ra1, input bit cr);
        int          ra [NUM_RD];
        bit          busy;
        bit          wacc;
        bit          eerr;
        logic [31:0] merged;
        ra[0] = ra0;
        ra[1] = ra1;
        wr_en = we;
        wr_addr = AW'(wa);
        wr_be = be;
        wr_data = wd;
        rd_en = re;
        rd_addr = {AW'(ra1), AW'(ra0)};
        clr_req = cr;
`ifdef REGFILE_PARITY_EN
        wr_perr_inj = inj;
`endif
        busy = clr_left > 0;
        wacc = we && !busy && (wa < DEPTH);
        merged = wacc ? ref_mem[wa] : 32'h0;
        for (int b = 0; b < NB; b++)
            if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
        eerr = we && !busy && (wa >= DEPTH);
        for (int p = 0; p < NUM_RD; p++) begin
            if (re[p]) begin
                if (ra[p] >= DEPTH) eerr = 1'b1;
                if (busy || ra[p] >= DEPTH) begin
                    exp_data[p] = '0;
                    exp_perr[p] = 1'b0;
                end else if (wacc && wa == ra[p]) begin
                    exp_data[p] = merged;
                    exp_perr[p] = be[0] ? inj : ref_bad[wa];
                end else begin
                    exp_data[p] = ref_mem[ra[p]];
                    exp_perr[p] = ref_bad[ra[p]];
                end
            end
        end
        if (wacc) begin
            ref_mem[wa] = merged;
            if (be[0]) ref_bad[wa] = inj;
        end
        if (busy) begin
            clr_left--;
        end else if (cr) begin
            clr_left = DEPTH;
            for (int a = 0; a < DEPTH; a++) begin
                ref_mem[a] = '0;
                ref_bad[a] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(re, eerr);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        do_reset();

        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 4'h0, 0, 2'b11, a, DEPTH - 1 - a, 0);

        step(1, 3, 4'hF, 32'hDEADBEEF, 2'b00, 0, 0, 0);
        step(1, 3, 4'h1, 32'h000000AA, 2'b00, 0, 0, 0);
        step(0, 0, 4'h0, 0, 2'b01, 3, 0, 0);
        chk("t2_merge", rd_data[31:0], 32'hDEADBEAA);

        step(1, 5, 4'hF, 32'h12345678, 2'b01, 5, 0, 0);
        chk("t3_bypass", rd_data[31:0], 32'h12345678);

        step(1, 11, 4'hF, 32'hCAFEF00D, 2'b00, 0, 0, 0);
        step(0, 0, 4'h0, 0, 2'b11, 11, 11, 0);
        chk("t4_last_p0", rd_data[31:0], 32'hCAFEF00D);
        chk("t4_last_p1", rd_data[63:32], 32'hCAFEF00D);
        step(0, 0, 4'h0, 0, 2'b01, 13, 0, 0);
        chk("t4_oor_err", addr_err, 1);
        step(1, 14, 4'hF, 32'hFFFFFFFF, 2'b00, 0, 0, 0);
        chk("t4_oor_wr_err", addr_err, 1);
        step(0, 0, 4'h0, 0, 2'b00, 0, 0, 0);
        chk("t4_err_pulse", addr_err, 0);

        for (int a = 0; a < DEPTH; a++)
            step(1, a, 4'hF, $urandom, 2'b00, 0, 0, 0);
        step(1, 7, 4'hF, 32'h00000077, 2'b01, 7, 0, 1);
        chk("t5_req_bypass", rd_data[31:0], 32'h00000077);
        nb = clr_busy ? 1 : 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(i == 5, 2, 4'hF, 32'h55AA55AA, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15), $urandom_range(0, 15), i == 3);
            if (clr_busy) nb++;
        end
        chk("t5_busy_cycles", nb, DEPTH);
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 4'h0, 0, 2'b11, a, a, 0);

        for (int i = 0; i < 400; i++) begin
            inj = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                 4'($urandom_range(0, 15)), $urandom,
                 2'($urandom_range(0, 3)), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 39) == 0);
        end
        inj = 1'b0;
        while (clr_left > 0)
            step(0, 0, 4'h0, 0, 2'b00, 0, 0, 0);

        for (int a = 0; a < DEPTH; a++)
            step(1, a, 4'hF, 32'hA5000000 | a, 2'b00, 0, 0, 0);
        step(0, 0, 4'h0, 0, 2'b00, 0, 0, 1);
        step(0, 0, 4'h0, 0, 2'b00, 0, 0, 0);
        step(0, 0, 4'h0, 0, 2'b00, 0, 0, 0);
        do_reset();
        chk("t6_rst_busy", clr_busy, 0);
        for (int a = 0; a < DEPTH; a++)
            step(0, 0, 4'h0, 0, 2'b11, a, DEPTH - 1 - a, 0);

`ifdef REGFILE_PARITY_EN
        inj = 1'b1;
        step(1, 2, 4'hF, 32'h01020304, 2'b00, 0, 0, 0);
        inj = 1'b0;
        step(0, 0, 4'h0, 0, 2'b01, 2, 0, 0);
        chk("t7_perr_inj", rd_perr[0], 1);
        step(1, 2, 4'hF, 32'h01020304, 2'b00, 0, 0, 0);
        step(0, 0, 4'h0, 0, 2'b01, 2, 0, 0);
        chk("t7_perr_clean", rd_perr[0], 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
